// File: rtl/axi_adc_jesd204_cpack.sv
// JESD204 ADC channel packer: compacts enabled channels sample-major per beat,
// then accumulates beats into full-width DMA words with a resync flag.

module cpack_lane #(
  parameter int NUM_CHANNELS    = 4,
  parameter int DATA_PATH_WIDTH = 2,
  parameter int LANE            = 0,
  parameter int ECW             = 3
) (
  input  logic [LANE:0]                          enable,
  input  logic [ECW-1:0]                         e_cnt,
  input  logic [16*DATA_PATH_WIDTH-1:0]          data,
  output logic [NUM_CHANNELS*16*DATA_PATH_WIDTH-1:0] placed
);
  int rank;

  // Sample k of this lane lands at slot k*E + (enabled lanes below this one).
  always_comb begin
    placed = '0;
    rank   = 0;
    for (int i = 0; i < LANE; i++) rank = rank + int'(enable[i]);
    if (enable[LANE])
      for (int k = 0; k < DATA_PATH_WIDTH; k++)
        placed[(k*int'(e_cnt) + rank)*16 +: 16] = data[16*k +: 16];
  end
endmodule

module axi_adc_jesd204_cpack #(
  parameter int NUM_CHANNELS    = 4,
  parameter int DATA_PATH_WIDTH = 2
) (
  input  logic                                    adc_clk,
  input  logic                                    adc_rstn,
  input  logic                                    adc_valid,
  input  logic [NUM_CHANNELS-1:0]                 adc_enable,
  input  logic [NUM_CHANNELS*16*DATA_PATH_WIDTH-1:0] adc_data,
  output logic                                    adc_wr_en,
  output logic [NUM_CHANNELS*16*DATA_PATH_WIDTH-1:0] adc_wr_data,
  output logic                                    adc_wr_sync,
  output logic                                    adc_pack_err
);
  localparam int S     = 16*DATA_PATH_WIDTH;
  localparam int W     = NUM_CHANNELS*S;
  localparam int ECW   = $clog2(NUM_CHANNELS+1);
  localparam int LOG_N = $clog2(NUM_CHANNELS);
  localparam int PW    = (NUM_CHANNELS > 1) ? LOG_N : 1;

  typedef struct packed {
    logic         vld;
    logic [3:0]   le;
    logic [W-1:0] data;
  } s1_t;

  logic [NUM_CHANNELS-1:0]        en_q;
  logic [ECW-1:0]                 e_cnt;
  logic                           legal, mask_chg, pack_err_nxt;
  logic [3:0]                     le_in;
  logic [NUM_CHANNELS-1:0][W-1:0] lane_out;
  logic [W-1:0]                   beat;
  s1_t                            s1;
  logic [PW-1:0]                  pos;
  logic [W-1:0]                   acc, acc_nxt;
  logic                           sync, last;
  int                             off;

  always_comb begin
    e_cnt = '0;
    for (int n = 0; n < NUM_CHANNELS; n++) e_cnt = e_cnt + ECW'(adc_enable[n]);
    legal        = (e_cnt != '0) && ((e_cnt & (e_cnt - ECW'(1))) == '0);
    pack_err_nxt = (e_cnt != '0) && !legal;
    mask_chg     = adc_enable != en_q;
    le_in = '0;
    for (int i = 0; i <= LOG_N; i++)
      if (int'(e_cnt) == (1 << i)) le_in = 4'(i);
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
    cpack_lane #(
      .NUM_CHANNELS(NUM_CHANNELS), .DATA_PATH_WIDTH(DATA_PATH_WIDTH),
      .LANE(g), .ECW(ECW)
    ) u_lane (
      .enable(adc_enable[g:0]),
      .e_cnt (e_cnt),
      .data  (adc_data[g*S +: S]),
      .placed(lane_out[g])
    );
  end

  always_comb begin
    beat = '0;
    for (int g = 0; g < NUM_CHANNELS; g++) beat = beat | lane_out[g];
  end

  // Slot 0 starts a fresh word, so stale upper bits never leak forward.
  always_comb begin
    off     = (int'(pos) << s1.le) * S;
    acc_nxt = ((pos == '0) ? {W{1'b0}} : acc) | (s1.data << off);
    last    = (int'(pos) + 1) == (NUM_CHANNELS >> s1.le);
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      en_q         <= '0;
      s1           <= '0;
      pos          <= '0;
      acc          <= '0;
      sync         <= 1'b1;
      adc_wr_en    <= 1'b0;
      adc_wr_data  <= '0;
      adc_wr_sync  <= 1'b0;
      adc_pack_err <= 1'b0;
    end else begin
      en_q         <= adc_enable;
      adc_pack_err <= pack_err_nxt;
      s1.vld       <= adc_valid && legal;
      if (adc_valid && legal) begin
        s1.le   <= le_in;
        s1.data <= beat;
      end
      adc_wr_en   <= 1'b0;
      adc_wr_sync <= 1'b0;
      // A mask change drops the beat in stage 1 and any partial word.
      if (mask_chg) begin
        pos  <= '0;
        sync <= 1'b1;
      end else if (s1.vld) begin
        acc <= acc_nxt;
        if (last) begin
          adc_wr_en   <= 1'b1;
          adc_wr_data <= acc_nxt;
          adc_wr_sync <= sync;
          sync        <= 1'b0;
          pos         <= '0;
        end else begin
          pos <= pos + PW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_adc_jesd204_cpack.sv
// Scoreboard bench for axi_adc_jesd204_cpack (N=4, D=2): directed beats,
// expected words queued at issue time, checked by an independent monitor.

module tb_axi_adc_jesd204_cpack;
  logic         adc_clk = 1'b0;
  logic         adc_rstn;
  logic         adc_valid;
  logic [3:0]   adc_enable;
  logic [127:0] adc_data;
  logic         adc_wr_en;
  logic [127:0] adc_wr_data;
  logic         adc_wr_sync;
  logic         adc_pack_err;

  typedef struct packed {
    logic [127:0] data;
    logic         sync;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 adc_clk = ~adc_clk;

  axi_adc_jesd204_cpack #(.NUM_CHANNELS(4), .DATA_PATH_WIDTH(2)) dut (
    .adc_clk     (adc_clk),
    .adc_rstn    (adc_rstn),
    .adc_valid   (adc_valid),
    .adc_enable  (adc_enable),
    .adc_data    (adc_data),
    .adc_wr_en   (adc_wr_en),
    .adc_wr_data (adc_wr_data),
    .adc_wr_sync (adc_wr_sync),
    .adc_pack_err(adc_pack_err)
  );

  // Input pattern: channel n sample k = {p, n, k, 0}
  function automatic logic [127:0] mk_all(input logic [3:0] p);
    logic [127:0] r;
    r = '0;
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 2; k++)
        r[n*32 + k*16 +: 16] = {p, 4'(n), 4'(k), 4'h0};
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic cyc(input logic v, input logic [127:0] d);
    adc_valid = v;
    adc_data  = d;
    @(posedge adc_clk);
    #1;
  endtask

  task automatic expect_word(input logic [127:0] d, input logic s);
    exp_t e;
    e.data = d;
    e.sync = s;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobed word must match the head of the scoreboard.
  always @(negedge adc_clk) begin
    if (adc_rstn && adc_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h sync %b, none expected", adc_wr_data, adc_wr_sync);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_data", adc_wr_data, e.data);
        chk("wr_sync", 128'(adc_wr_sync), 128'(e.sync));
      end
    end
  end

  initial begin
    adc_rstn   = 1'b0;
    adc_valid  = 1'b0;
    adc_enable = 4'b0000;
    adc_data   = '0;
    #3;
    chk("rst_wr_en", 128'(adc_wr_en), 128'd0);
    chk("rst_wr_data", adc_wr_data, 128'd0);
    chk("rst_wr_sync", 128'(adc_wr_sync), 128'd0);
    chk("rst_pack_err", 128'(adc_pack_err), 128'd0);
    @(posedge adc_clk);
    #1;
    adc_rstn = 1'b1;

    // Full mask: one beat is one word, first word after reset carries sync.
    adc_enable = 4'b1111;
    expect_word(128'h0310_0210_0110_0010_0300_0200_0100_0000, 1'b1);
    cyc(1'b1, mk_all(4'h0));
    cyc(1'b0, '0);
    cyc(1'b0, '0);

    // Channels 0 and 2: two beats per word, disabled channels ignored.
    adc_enable = 4'b0101;
    cyc(1'b0, '0);
    expect_word(128'hD010_B010_D000_B000_C010_A010_C000_A000, 1'b1);
    cyc(1'b1, {32'hFFFF_FFFF, 32'hC010_C000, 32'hFFFF_FFFF, 32'hA010_A000});
    cyc(1'b1, {32'hFFFF_FFFF, 32'hD010_D000, 32'hFFFF_FFFF, 32'hB010_B000});
    cyc(1'b0, '0);
    cyc(1'b0, '0);

    // Single channel, valid toggling: idle cycles must not advance the slot.
    adc_enable = 4'b0001;
    cyc(1'b0, '0);
    expect_word(128'h4401_4400_3301_3300_2201_2200_1101_1100, 1'b1);
    cyc(1'b1, {96'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE, 32'h1101_1100});
    cyc(1'b0, {96'h0, 32'h5555_5555});
    cyc(1'b1, {96'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE, 32'h2201_2200});
    cyc(1'b0, {96'h0, 32'h6666_6666});
    cyc(1'b1, {96'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE, 32'h3301_3300});
    cyc(1'b0, {96'h0, 32'h7777_7777});
    cyc(1'b1, {96'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE, 32'h4401_4400});
    cyc(1'b0, '0);
    cyc(1'b0, '0);

    // Partial word dropped by mask change; change-cycle beat uses new mask.
    adc_enable = 4'b0011;
    cyc(1'b0, '0);
    cyc(1'b1, mk_all(4'h4));
    adc_enable = 4'b1111;
    expect_word(128'h5310_5210_5110_5010_5300_5200_5100_5000, 1'b1);
    expect_word(128'h6310_6210_6110_6010_6300_6200_6100_6000, 1'b0);
    cyc(1'b1, mk_all(4'h5));
    cyc(1'b1, mk_all(4'h6));
    cyc(1'b0, '0);
    cyc(1'b0, '0);

    // Mask change while the word-completing beat is in stage 1: no word.
    adc_enable = 4'b0011;
    cyc(1'b0, '0);
    cyc(1'b1, mk_all(4'h8));
    cyc(1'b1, mk_all(4'h9));
    adc_enable = 4'b1111;
    cyc(1'b0, '0);
    expect_word(128'hA310_A210_A110_A010_A300_A200_A100_A000, 1'b1);
    cyc(1'b1, mk_all(4'hA));
    cyc(1'b0, '0);
    cyc(1'b0, '0);

    // Empty mask: no error flag, no output.
    adc_enable = 4'b0000;
    cyc(1'b0, '0);
    chk("err_empty_mask", 128'(adc_pack_err), 128'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, mk_all(4'hB));

    // Three channels: error after one cycle, nothing accepted.
    adc_enable = 4'b0111;
    cyc(1'b0, '0);
    chk("err_three_ch", 128'(adc_pack_err), 128'd1);
    for (int i = 0; i < 20; i++) cyc(1'b1, mk_all(4'hC));
    chk("err_held", 128'(adc_pack_err), 128'd1);
    adc_enable = 4'b1111;
    expect_word(128'h7310_7210_7110_7010_7300_7200_7100_7000, 1'b1);
    cyc(1'b1, mk_all(4'h7));
    chk("err_cleared", 128'(adc_pack_err), 128'd0);
    cyc(1'b0, '0);
    cyc(1'b0, '0);

    // Reset mid-word: outputs clear at once, partial word is lost.
    adc_enable = 4'b0011;
    cyc(1'b0, '0);
    cyc(1'b1, mk_all(4'hD));
    cyc(1'b0, '0);
    adc_rstn = 1'b0;
    #1;
    chk("rst_mid_wr_en", 128'(adc_wr_en), 128'd0);
    chk("rst_mid_wr_data", adc_wr_data, 128'd0);
    chk("rst_mid_wr_sync", 128'(adc_wr_sync), 128'd0);
    chk("rst_mid_pack_err", 128'(adc_pack_err), 128'd0);
    @(posedge adc_clk);
    #1;
    adc_rstn = 1'b1;
    expect_word(128'h9110_9010_9100_9000_8110_8010_8100_8000, 1'b1);
    cyc(1'b1, mk_all(4'h8));
    cyc(1'b1, mk_all(4'h9));

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1'b0, '0);
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    chk("words_outstanding", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
